// File: rtl/lif_param_pkg.sv
// Shared constants, field layout and FSM state type for the neuron parameter serial link.
package lif_param_pkg;

    localparam int FIELD_W    = 8;
    localparam int NUM_FIELDS = 6;

    localparam logic [2:0] FLD_WA    = 3'd0;
    localparam logic [2:0] FLD_LR1   = 3'd1;
    localparam logic [2:0] FLD_LR2   = 3'd2;
    localparam logic [2:0] FLD_THMIN = 3'd3;
    localparam logic [2:0] FLD_LC1   = 3'd4;
    localparam logic [2:0] FLD_LC2   = 3'd5;

    localparam int WA_W    = 3;
    localparam int LR1_W   = 8;
    localparam int LR2_W   = 8;
    localparam int THMIN_W = 8;
    localparam int LC1_W   = 4;
    localparam int LC2_W   = 4;

    localparam logic [WA_W-1:0]    WA_DEFAULT    = 3'd2;
    localparam logic [LR1_W-1:0]   LR1_DEFAULT   = 8'd2;
    localparam logic [LR2_W-1:0]   LR2_DEFAULT   = 8'd1;
    localparam logic [THMIN_W-1:0] THMIN_DEFAULT = 8'd30;
    localparam logic [LC1_W-1:0]   LC1_DEFAULT   = 4'd2;
    localparam logic [LC2_W-1:0]   LC2_DEFAULT   = 4'd4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HEADER  = 2'd1,
        ST_SHIFT   = 2'd2,
        ST_RELEASE = 2'd3
    } ser_state_t;

    typedef struct packed {
        logic [WA_W-1:0]    weight_a;
        logic [LR1_W-1:0]   leak_rate_1;
        logic [LR2_W-1:0]   leak_rate_2;
        logic [THMIN_W-1:0] threshold_min;
        logic [LC1_W-1:0]   leak_cycles_1;
        logic [LC2_W-1:0]   leak_cycles_2;
    } param_set_t;

    // Wire encoding of one field; out-of-range indices read as zero.
    function automatic logic [FIELD_W-1:0] field_value(input param_set_t p, input logic [2:0] idx);
        logic [FIELD_W-1:0] v;
        v = '0;
        case (idx)
            FLD_WA:    v = {5'b0, p.weight_a};
            FLD_LR1:   v = p.leak_rate_1;
            FLD_LR2:   v = p.leak_rate_2;
            FLD_THMIN: v = p.threshold_min;
            FLD_LC1:   v = {4'b0, p.leak_cycles_1};
            FLD_LC2:   v = {4'b0, p.leak_cycles_2};
            default:   v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/lif_param_serializer_piso8.sv
// 8-bit parallel-load, MSB-first shift register with load/shift/hold, advanced only on enable.
module lif_piso8
    import lif_param_pkg::*;
(
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               load,
    input  logic               shift,
    input  logic [FIELD_W-1:0] din,
    output logic               msb
);

    logic [FIELD_W-1:0] sr;

    always_ff @(posedge clk) begin
        if (reset) begin
            sr <= '0;
        end else if (enable) begin
            if (load) begin
                sr <= din;
            end else if (shift) begin
                sr <= {sr[FIELD_W-2:0], 1'b0};
            end
        end
    end

    assign msb = sr[FIELD_W-1];

endmodule

// File: rtl/lif_param_serializer.sv
// Transmit end of the neuron parameter link: snapshots six fields on start and frames them serially.
// Optional abort support is compiled in with PARAM_SER_ABORT_EN.
module lif_param_serializer
    import lif_param_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic         start,
    input  logic         abort,
    input  logic [2:0]   weight_a_in,
    input  logic [7:0]   leak_rate_1_in,
    input  logic [7:0]   leak_rate_2_in,
    input  logic [7:0]   threshold_min_in,
    input  logic [3:0]   leak_cycles_1_in,
    input  logic [3:0]   leak_cycles_2_in,
    output logic         serial_data_out,
    output logic         load_enable_out,
    output logic         busy,
    output logic         done,
    output ser_state_t   fsm_state
);

    localparam logic [2:0] LAST_FIELD = 3'(NUM_FIELDS - 1);

    ser_state_t   state, state_nx;
    logic [2:0]   field_idx, field_idx_nx;
    logic [2:0]   bit_idx, bit_idx_nx;
    param_set_t   snap, snap_nx;
    logic         serial_nx, load_en_nx, busy_nx, done_nx;
    logic         piso_load, piso_shift, piso_msb;
    logic [FIELD_W-1:0] piso_din;
    logic         abort_hit;

`ifdef PARAM_SER_ABORT_EN
    assign abort_hit = abort;
`else
    logic abort_unused;
    assign abort_unused = abort;
    assign abort_hit    = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= ST_IDLE;
            field_idx       <= '0;
            bit_idx         <= '0;
            snap            <= '0;
            serial_data_out <= 1'b0;
            load_enable_out <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
        end else if (enable) begin
            state           <= state_nx;
            field_idx       <= field_idx_nx;
            bit_idx         <= bit_idx_nx;
            snap            <= snap_nx;
            serial_data_out <= serial_nx;
            load_enable_out <= load_en_nx;
            busy            <= busy_nx;
            done            <= done_nx;
        end
    end

    // The shifter always holds the bit to drive next; it is reloaded with the
    // following field on the edge that puts bit 0 of the current field on the wire.
    always_comb begin
        state_nx     = state;
        field_idx_nx = field_idx;
        bit_idx_nx   = bit_idx;
        snap_nx      = snap;
        serial_nx    = serial_data_out;
        load_en_nx   = load_enable_out;
        busy_nx      = busy;
        done_nx      = done;
        piso_load    = 1'b0;
        piso_shift   = 1'b0;
        piso_din     = field_value(snap, field_idx + 3'd1);

        case (state)
            ST_IDLE: begin
                done_nx = 1'b0;
                if (start) begin
                    snap_nx    = {weight_a_in, leak_rate_1_in, leak_rate_2_in,
                                  threshold_min_in, leak_cycles_1_in, leak_cycles_2_in};
                    load_en_nx = 1'b1;
                    serial_nx  = 1'b0;
                    busy_nx    = 1'b1;
                    piso_load  = 1'b1;
                    piso_din   = {5'b0, weight_a_in};
                    state_nx   = ST_HEADER;
                end
            end
            ST_HEADER: begin
                if (abort_hit) begin
                    load_en_nx = 1'b0;
                    serial_nx  = 1'b0;
                    busy_nx    = 1'b0;
                    state_nx   = ST_IDLE;
                end else begin
                    serial_nx    = piso_msb;
                    field_idx_nx = FLD_WA;
                    bit_idx_nx   = 3'd7;
                    piso_shift   = 1'b1;
                    state_nx     = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                if (abort_hit) begin
                    load_en_nx = 1'b0;
                    serial_nx  = 1'b0;
                    busy_nx    = 1'b0;
                    state_nx   = ST_IDLE;
                end else if (bit_idx == 3'd0 && field_idx == LAST_FIELD) begin
                    load_en_nx = 1'b0;
                    serial_nx  = 1'b0;
                    state_nx   = ST_RELEASE;
                end else if (bit_idx == 3'd0) begin
                    field_idx_nx = field_idx + 3'd1;
                    bit_idx_nx   = 3'd7;
                    serial_nx    = piso_msb;
                    piso_shift   = 1'b1;
                end else begin
                    bit_idx_nx = bit_idx - 3'd1;
                    serial_nx  = piso_msb;
                    if (bit_idx == 3'd1) begin
                        piso_load = 1'b1;
                    end else begin
                        piso_shift = 1'b1;
                    end
                end
            end
            ST_RELEASE: begin
                busy_nx  = 1'b0;
                done_nx  = 1'b1;
                state_nx = ST_IDLE;
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    lif_piso8 u_piso (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .load   (piso_load),
        .shift  (piso_shift),
        .din    (piso_din),
        .msb    (piso_msb)
    );

    assign fsm_state = state;

endmodule

// File: tb/tb_lif_param_serializer.sv
// Scoreboarded bench for lif_param_serializer: stimulus queues expected frames, a monitor deserializes and checks.
module tb_lif_param_serializer;
    import lif_param_pkg::*;

`ifdef PARAM_SER_ABORT_EN
    localparam bit ABORT_EN = 1'b1;
`else
    localparam bit ABORT_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset, enable, start, abort;
    logic [2:0] weight_a_in;
    logic [7:0] leak_rate_1_in, leak_rate_2_in, threshold_min_in;
    logic [3:0] leak_cycles_1_in, leak_cycles_2_in;
    logic       serial_data_out, load_enable_out, busy, done;
    ser_state_t fsm_state;

    // {expected data-bit count, 48-bit frame}
    logic [55:0] exp_q[$];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lif_param_serializer dut (
        .clk              (clk),
        .reset            (reset),
        .enable           (enable),
        .start            (start),
        .abort            (abort),
        .weight_a_in      (weight_a_in),
        .leak_rate_1_in   (leak_rate_1_in),
        .leak_rate_2_in   (leak_rate_2_in),
        .threshold_min_in (threshold_min_in),
        .leak_cycles_1_in (leak_cycles_1_in),
        .leak_cycles_2_in (leak_cycles_2_in),
        .serial_data_out  (serial_data_out),
        .load_enable_out  (load_enable_out),
        .busy             (busy),
        .done             (done),
        .fsm_state        (fsm_state)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic set_params(input logic [2:0] wa, input logic [7:0] lr1, input logic [7:0] lr2,
                              input logic [7:0] th, input logic [3:0] lc1, input logic [3:0] lc2);
        weight_a_in      = wa;
        leak_rate_1_in   = lr1;
        leak_rate_2_in   = lr2;
        threshold_min_in = th;
        leak_cycles_1_in = lc1;
        leak_cycles_2_in = lc2;
    endtask

    // Loader-side model: one header cycle, then one bit per enabled edge while the envelope is high.
    initial begin : monitor
        logic        en_s, rst_s, in_frame;
        logic [47:0] bits;
        logic [55:0] e;
        int          n;
        in_frame = 1'b0;
        bits     = '0;
        n        = 0;
        forever begin
            @(posedge clk);
            en_s  = enable;
            rst_s = reset;
            #1;
            if (en_s || rst_s) begin
                if (load_enable_out) begin
                    if (!in_frame) begin
                        in_frame = 1'b1;
                        bits     = '0;
                        n        = 0;
                        check("header_bit", 64'(serial_data_out), 64'd0);
                    end else begin
                        bits = {bits[46:0], serial_data_out};
                        n++;
                    end
                end else if (in_frame) begin
                    in_frame = 1'b0;
                    check("frame_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check("frame_bit_count", 64'(n), 64'(e[55:48]));
                        check("frame_data", 64'(bits), 64'(e[47:0] >> (48 - int'(e[55:48]))));
                    end
                end
            end
        end
    end

    // s1/s2: enabled-edge numbers to pulse start; rst_at/abt_at: edge to assert reset/abort (0 = none).
    task automatic run_frame(input bit toggle, input int s1, input int s2, input int rst_at,
                             input int abt_at, input bit scramble, input logic [47:0] expv,
                             input int exp_cycles);
        int  cyc, busy_n, cut_at;
        bit  stop;
        @(negedge clk);
        enable = 1'b1;
        start  = 1'b1;
        cut_at = (rst_at > 0) ? rst_at : ((ABORT_EN && abt_at > 0) ? abt_at : 0);
        exp_q.push_back({8'((cut_at > 0) ? cut_at - 1 : 48), expv});
        @(posedge clk);
        #1;
        busy_n = int'(busy);
        cyc    = 0;
        stop   = 1'b0;
        while (!stop && cyc < 400) begin
            @(negedge clk);
            start = (cyc + 1 == s1) || (cyc + 1 == s2);
            reset = (cyc + 1 == rst_at);
            abort = (cyc + 1 == abt_at);
            if (toggle) enable = ~enable;
            if (scramble && cyc + 1 <= 40)
                set_params(3'($urandom_range(0, 7)), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                           8'($urandom_range(0, 255)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
            @(posedge clk);
            cyc++;
            #1;
            if (reset || (ABORT_EN && abort)) begin
                check(reset ? "reset_load_enable" : "abort_load_enable", 64'(load_enable_out), 64'd0);
                check(reset ? "reset_busy" : "abort_busy", 64'(busy), 64'd0);
                stop = 1'b1;
            end else begin
                if (enable) busy_n += int'(busy);
                if (done) stop = 1'b1;
            end
        end
        @(negedge clk);
        reset  = 1'b0;
        abort  = 1'b0;
        start  = 1'b0;
        enable = 1'b1;
        if (cut_at > 0) begin
            repeat (5) begin
                @(posedge clk);
                #1;
                check("no_done_after_cut", 64'(done), 64'd0);
            end
        end else begin
            check("cycles_start_to_done", 64'(cyc), 64'(exp_cycles));
            check("busy_enabled_cycles", 64'(busy_n), 64'd50);
            @(posedge clk);
            #1;
            check("done_single_pulse", 64'(done), 64'd0);
            check("busy_after_done", 64'(busy), 64'd0);
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'b1;
        start  = 1'b0;
        abort  = 1'b0;
        set_params(3'd0, 8'd0, 8'd0, 8'd0, 4'd0, 4'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_load_enable", 64'(load_enable_out), 64'd0);
        check("reset_serial", 64'(serial_data_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_done", 64'(done), 64'd0);
        check("reset_state", 64'(fsm_state), 64'(ST_IDLE));
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);

        // Basic frame, continuous enable
        set_params(3'd5, 8'hA5, 8'h3C, 8'h7F, 4'h9, 4'hC);
        run_frame(1'b0, 0, 0, 0, 0, 1'b0, 48'h05A53C7F090C, 50);

        // Same frame with enable toggling every cycle
        run_frame(1'b1, 0, 0, 0, 0, 1'b0, 48'h05A53C7F090C, 100);

        // Start pulses mid-frame are ignored
        set_params(3'd3, 8'h81, 8'h00, 8'hFF, 4'h1, 4'hF);
        run_frame(1'b0, 10, 30, 0, 0, 1'b0, 48'h038100FF010F, 50);

        // Start while in RELEASE is ignored
        run_frame(1'b0, 50, 0, 0, 0, 1'b0, 48'h038100FF010F, 50);

        // Reset mid-frame, then a clean frame
        set_params(3'd5, 8'hA5, 8'h3C, 8'h7F, 4'h9, 4'hC);
        run_frame(1'b0, 0, 0, 20, 0, 1'b0, 48'h05A53C7F090C, 50);
        set_params(3'd3, 8'h81, 8'h00, 8'hFF, 4'h1, 4'hF);
        run_frame(1'b0, 0, 0, 0, 0, 1'b0, 48'h038100FF010F, 50);

        // Abort at E20: truncated frame when enabled, full frame otherwise
        set_params(3'd5, 8'hA5, 8'h3C, 8'h7F, 4'h9, 4'hC);
        run_frame(1'b0, 0, 0, 0, 20, 1'b0, 48'h05A53C7F090C, 50);

        // Inputs scrambled after start: frame carries the E0 snapshot
        set_params(3'd5, 8'hA5, 8'h3C, 8'h7F, 4'h9, 4'hC);
        run_frame(1'b0, 0, 0, 0, 0, 1'b1, 48'h05A53C7F090C, 50);

        repeat (5) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
